// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential single-precision FPU.
// Holds the op_sel encodings, IEEE-754 field widths, canned result
// constants, flag bit positions, the controller state enum and a
// leading-zero counter used by the normaliser.
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int DIV_ITERS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_DIV_ZERO  = 2;
  localparam int FLG_OVERFLOW  = 1;
  localparam int FLG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    FPU_OP_ADD = 2'b00,
    FPU_OP_SUB = 2'b01,
    FPU_OP_MUL = 2'b10,
    FPU_OP_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_EXEC,
    ST_DIV,
    ST_NORM,
    ST_DONE
  } fpu_state_e;

  // Returns 0 for an all-zero input; callers treat zero separately.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    lzc27 = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        found = 1'b1;
        lzc27 = 5'(26 - i);
      end
    end
  endfunction

endpackage

// File: rtl/fpu_div_iter.sv
// Restoring mantissa divider: one quotient bit per clock, DIV_ITERS bits.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start_i         load dividend/divisor (both 24-bit with hidden bit)
//   dividend_i      numerator mantissa
//   divisor_i       denominator mantissa
//   busy_o          iterations remain
//   done_o          high during the cycle whose edge produces the last bit
//   quot_o          26-bit quotient, bit 25 has weight 1
//   sticky_o        final remainder is non-zero
module fpu_div_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [23:0] dividend_i,
  input  logic [23:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [25:0] quot_o,
  output logic        sticky_o
);

  logic [24:0] rem_q;
  logic [23:0] dvs_q;
  logic [25:0] quot_q;
  logic [4:0]  cnt_q;
  logic [25:0] trial;

  // Remainder stays below twice the divisor, so 25 bits plus a sign suffice.
  assign trial = {1'b0, rem_q} - {2'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      rem_q  <= {1'b0, dividend_i};
      dvs_q  <= divisor_i;
      quot_q <= '0;
      cnt_q  <= 5'(DIV_ITERS);
    end else if (cnt_q != 5'd0) begin
      if (!trial[25]) begin
        rem_q  <= trial[24:0] << 1;
        quot_q <= {quot_q[24:0], 1'b1};
      end else begin
        rem_q  <= rem_q << 1;
        quot_q <= {quot_q[24:0], 1'b0};
      end
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign busy_o   = (cnt_q != 5'd0);
  assign done_o   = (cnt_q == 5'd1);
  assign quot_o   = quot_q;
  assign sticky_o = (rem_q != '0);

endmodule

// File: rtl/fpu_seq_core.sv
// Sequential IEEE-754 single-precision add/sub/mul/div with valid/ready
// on both request and result sides.
// Ports:
//   clk, rst_n              clock / async active-low reset
//   in_valid, in_ready      request handshake
//   a, b, op_sel            operands and operation (00 add, 01 sub, 10 mul, 11 div)
//   out_valid, out_ready    result handshake
//   result, flags           result word, {invalid, div_by_zero, overflow, underflow}
// Build option FPU_SPECIAL_CASES_EN: NaN/Inf/zero handling with invalid and
// div_by_zero flags. Without it exp==255 is an ordinary exponent and x/0
// returns signed Inf silently.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// UNPACK | split fields, flush denormals, resolve bypass results, start divider
// EXEC   | align+add/sub or 24x24 multiply
// DIV    | divider iterating, one quotient bit per cycle
// NORM   | normalise, round to nearest even, range check, pack
// DONE   | out_valid high, hold until out_ready
module fpu_seq_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  fpu_state_e state_q, state_d;
  fpu_op_e    op_q;
  logic [31:0] a_q, b_q, result_q, res_d, byp_res_q, byp_res_d;
  logic [3:0]  flags_q, flg_d, byp_flg_q, byp_flg_d;
  logic        byp_q, byp_d;
  logic        sa_q, sb_q, n_sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;
  logic signed [9:0] n_exp_q;
  logic [27:0] n_man_q;

  // Unpack straight from the captured operands; sb is the effective sign.
  logic        ua_sb, zero_b, s_x;
  logic [23:0] ua_ma, ua_mb;
  assign ua_sb  = b_q[31] ^ (op_q == FPU_OP_SUB);
  assign zero_b = (b_q[30:23] == 8'd0);
  assign s_x    = a_q[31] ^ b_q[31];
  assign ua_ma  = (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
  assign ua_mb  = zero_b ? 24'd0 : {1'b1, b_q[22:0]};

`ifdef FPU_SPECIAL_CASES_EN
  logic zero_a, nan_a, nan_b, inf_a, inf_b;
  assign zero_a = (a_q[30:23] == 8'd0);
  assign nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
`endif

  always_comb begin
    byp_d     = 1'b0;
    byp_res_d = '0;
    byp_flg_d = '0;
`ifdef FPU_SPECIAL_CASES_EN
    if (nan_a || nan_b) begin
      byp_d = 1'b1; byp_res_d = QNAN; byp_flg_d[FLG_INVALID] = 1'b1;
    end else begin
      case (op_q)
        FPU_OP_ADD, FPU_OP_SUB: begin
          if (inf_a && inf_b && (a_q[31] != ua_sb)) begin
            byp_d = 1'b1; byp_res_d = QNAN; byp_flg_d[FLG_INVALID] = 1'b1;
          end else if (inf_a) begin
            byp_d = 1'b1; byp_res_d = {a_q[31], POS_INF[30:0]};
          end else if (inf_b) begin
            byp_d = 1'b1; byp_res_d = {ua_sb, POS_INF[30:0]};
          end
        end
        FPU_OP_MUL: begin
          if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            byp_d = 1'b1; byp_res_d = QNAN; byp_flg_d[FLG_INVALID] = 1'b1;
          end else if (inf_a || inf_b) begin
            byp_d = 1'b1; byp_res_d = {s_x, POS_INF[30:0]};
          end
        end
        default: begin
          if ((zero_a && zero_b) || (inf_a && inf_b)) begin
            byp_d = 1'b1; byp_res_d = QNAN; byp_flg_d[FLG_INVALID] = 1'b1;
          end else if (zero_b) begin
            byp_d = 1'b1; byp_res_d = {s_x, POS_INF[30:0]}; byp_flg_d[FLG_DIV_ZERO] = 1'b1;
          end else if (inf_a) begin
            byp_d = 1'b1; byp_res_d = {s_x, POS_INF[30:0]};
          end else if (inf_b) begin
            byp_d = 1'b1; byp_res_d = {s_x, 31'd0};
          end
        end
      endcase
    end
`else
    if (op_q == FPU_OP_DIV && zero_b) begin
      byp_d = 1'b1; byp_res_d = {s_x, POS_INF[30:0]};
    end
`endif
  end

  // Add/sub: order by magnitude so the magnitude subtraction never goes negative.
  logic        a_big, s_big, s_sml;
  logic [7:0]  e_big, e_sml, e_diff;
  logic [23:0] m_big, m_sml;
  logic [4:0]  sh;
  logic [55:0] al_tmp;
  logic [27:0] m_al, m_sum;
  logic [47:0] prod;
  logic [27:0] mul_man;
  logic signed [9:0] mul_exp, div_exp;

  assign a_big  = {ea_q, ma_q} >= {eb_q, mb_q};
  assign e_big  = a_big ? ea_q : eb_q;
  assign e_sml  = a_big ? eb_q : ea_q;
  assign m_big  = a_big ? ma_q : mb_q;
  assign m_sml  = a_big ? mb_q : ma_q;
  assign s_big  = a_big ? sa_q : sb_q;
  assign s_sml  = a_big ? sb_q : sa_q;
  assign e_diff = e_big - e_sml;
  assign sh     = (e_diff > 8'd31) ? 5'd31 : e_diff[4:0];
  assign al_tmp = {1'b0, m_sml, 3'b000, 28'd0} >> sh;
  // Bits shifted past the round position collapse into the LSB as sticky.
  assign m_al   = {al_tmp[55:29], al_tmp[28] | (|al_tmp[27:0])};
  assign m_sum  = (s_big == s_sml) ? ({1'b0, m_big, 3'b000} + m_al)
                                   : ({1'b0, m_big, 3'b000} - m_al);

  assign prod    = ma_q * mb_q;
  assign mul_man = {prod[47:21], prod[20] | (|prod[19:0])};
  assign mul_exp = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
  assign div_exp = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;

  logic        div_start, div_busy, div_done, div_sticky;
  logic [25:0] div_quot;
  assign div_start = (state_q == ST_UNPACK) && (op_q == FPU_OP_DIV);

  fpu_div_iter u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (ua_ma),
    .divisor_i  (ua_mb),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .sticky_o   (div_sticky)
  );

  // Normaliser. Working format: bit 26 weight 1, bit 27 carry, [2:0] guard/round/sticky.
  logic [27:0] norm_man;
  logic [26:0] nm;
  logic signed [9:0] ne;
  logic [4:0]  lz;
  logic [23:0] rnd;
  logic        rup, nz;

  assign norm_man = (op_q == FPU_OP_DIV) ? {1'b0, div_quot, div_sticky} : n_man_q;

  always_comb begin
    res_d = '0;
    flg_d = '0;
    lz    = lzc27(norm_man[26:0]);
    if (norm_man[27]) begin
      nm = {norm_man[27:2], norm_man[1] | norm_man[0]};
      ne = n_exp_q + 10'sd1;
    end else begin
      nm = norm_man[26:0] << lz;
      ne = n_exp_q - $signed({5'd0, lz});
    end
    // The leading one is missing only when the magnitude is exactly zero.
    nz  = norm_man[27] | nm[26];
    rup = nm[2] & (nm[1] | nm[0] | nm[3]);
    rnd = {1'b0, nm[25:3]} + {23'd0, rup};
    ne  = ne + $signed({9'd0, rnd[23]});
    if (byp_q) begin
      res_d = byp_res_q;
      flg_d = byp_flg_q;
    end else if (!nz) begin
      res_d = {n_sign_q & (op_q == FPU_OP_MUL || op_q == FPU_OP_DIV), 31'd0};
    end else if (ne >= 10'sd255) begin
      res_d = {n_sign_q, POS_INF[30:0]};
      flg_d[FLG_OVERFLOW] = 1'b1;
    end else if (ne <= 10'sd0) begin
      res_d = {n_sign_q, 31'd0};
      flg_d[FLG_UNDERFLOW] = 1'b1;
    end else begin
      res_d = {n_sign_q, ne[7:0], rnd[22:0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_UNPACK;
      end
      ST_UNPACK: state_d = (op_q == FPU_OP_DIV) ? ST_DIV : ST_EXEC;
      ST_EXEC:   state_d = ST_NORM;
      // !div_busy is only a guard against ever parking here.
      ST_DIV:    if (div_done || !div_busy) state_d = ST_NORM;
      ST_NORM:   state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; op_q <= FPU_OP_ADD;
      result_q <= '0; flags_q <= '0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      byp_q <= 1'b0; byp_res_q <= '0; byp_flg_q <= '0;
      n_sign_q <= 1'b0; n_exp_q <= '0; n_man_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= fpu_op_e'(op_sel);
          flags_q <= '0;
        end
        ST_UNPACK: begin
          sa_q <= a_q[31];  sb_q <= ua_sb;
          ea_q <= a_q[30:23]; eb_q <= b_q[30:23];
          ma_q <= ua_ma;    mb_q <= ua_mb;
          byp_q <= byp_d; byp_res_q <= byp_res_d; byp_flg_q <= byp_flg_d;
        end
        ST_EXEC: begin
          n_sign_q <= (op_q == FPU_OP_MUL) ? (sa_q ^ sb_q) : s_big;
          n_exp_q  <= (op_q == FPU_OP_MUL) ? mul_exp : $signed({2'b00, e_big});
          n_man_q  <= (op_q == FPU_OP_MUL) ? mul_man : m_sum;
        end
        ST_DIV: begin
          n_sign_q <= sa_q ^ sb_q;
          n_exp_q  <= div_exp;
        end
        ST_NORM: begin
          result_q <= res_d;
          flags_q  <= flg_d;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_seq_core.sv
module tb_fpu_seq_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  op_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  fpu_seq_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sel    (op_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: samples on the falling edge, compares against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got result %h with nothing outstanding", result);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
        chk("result", result, sb[0].res);
        chk("flags", {28'd0, flags}, {28'd0, sb[0].flg});
        chk("in_ready_while_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen   = 1'b0;
          hs_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tbv, input logic [1:0] op,
                       input logic [31:0] er, input logic [3:0] ef, input int el);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tbv; op_sel = op; in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got   = 1'b1;
        e.res = er; e.flg = ef; e.lat = el; e.acc = cyc + 1;
        chk("accept_after_handshake", {31'd0, (e.acc > hs_cyc)}, 32'd1);
        sb.push_back(e);
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] ta, input logic [31:0] tbv, input logic [1:0] op,
                     input logic [31:0] er, input logic [3:0] ef, input int el);
    issue(ta, tbv, op, er, ef, el);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op_sel = ADD;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {28'd0, flags},     32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run(32'h40400000, 32'h40800000, ADD, 32'h40E00000, 4'b0000, 3);
    run(32'h40C00000, 32'h40800000, SUB, 32'h40000000, 4'b0000, 3);
    run(32'h3F800000, 32'hBF800000, ADD, 32'h00000000, 4'b0000, 3);
    run(32'h3F800000, 32'h3F800000, SUB, 32'h00000000, 4'b0000, 3);
    run(32'hC0400000, 32'hC0800000, ADD, 32'hC0E00000, 4'b0000, 3);
    run(32'h3F800000, 32'h33800000, ADD, 32'h3F800000, 4'b0000, 3);
    run(32'h3F800001, 32'h33800000, ADD, 32'h3F800002, 4'b0000, 3);
    run(32'h3F800000, 32'h40000000, MUL, 32'h40000000, 4'b0000, 3);
    run(32'h3FC00000, 32'h3FC00000, MUL, 32'h40100000, 4'b0000, 3);
    run(32'h7F000000, 32'h40000000, MUL, 32'h7F800000, 4'b0010, 3);
    run(32'h00800000, 32'h00800000, MUL, 32'h00000000, 4'b0001, 3);
    run(32'h40400000, 32'h40000000, DIV, 32'h3FC00000, 4'b0000, 28);
    run(32'h3F800000, 32'h40400000, DIV, 32'h3EAAAAAB, 4'b0000, 28);
    run(32'hC0C00000, 32'h40000000, DIV, 32'hC0400000, 4'b0000, 28);
`ifdef FPU_SPECIAL_CASES_EN
    run(32'h3F800000, 32'h00000000, DIV, 32'h7F800000, 4'b0100, 28);
    run(32'h7FC00001, 32'h3F800000, ADD, 32'h7FC00000, 4'b1000, 3);
    run(32'h00000000, 32'h7F800000, MUL, 32'h7FC00000, 4'b1000, 3);
`else
    run(32'h3F800000, 32'h00000000, DIV, 32'h7F800000, 4'b0000, 28);
`endif

    // Backpressure: result held 10+ cycles, next request waits with in_valid high.
    out_ready = 1'b0;
    issue(32'h40400000, 32'h40800000, ADD, 32'h40E00000, 4'b0000, 3);
    fork
      issue(32'h3F800000, 32'h40000000, MUL, 32'h40000000, 4'b0000, 3);
      begin
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a division: nothing may come out afterwards.
    issue(32'h40400000, 32'h40000000, DIV, 32'h3FC00000, 4'b0000, 28);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_result",    result,             32'd0);
    chk("post_rst_flags",     {28'd0, flags},     32'd0);
    repeat (40) @(negedge clk);
    chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

    run(32'h40400000, 32'h40800000, ADD, 32'h40E00000, 4'b0000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
